// File: rtl/newhope_xfer_ctrl.sv
// Transfer sequencer: moves keygen output into encrypter/decrypter RAMs (KEY mode) and
// encrypter ciphertext outputs into decrypter input RAMs (CT mode), one read per cycle.
module newhope_xfer_ctrl #(
  parameter int unsigned RD_LAT  = 1,
  parameter int unsigned PS_BASE = 1792,
  parameter int unsigned PK_BASE = 896,
  parameter int unsigned SK_BASE = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start_key,
  input  logic        i_start_ct,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_ovr,
  output logic [10:0] o_key_addr,
  input  logic [7:0]  i_key_do,
  output logic        o_enc_we_ps,
  output logic [2:0]  o_enc_addr_ps,
  output logic [31:0] o_enc_di_ps,
  output logic        o_enc_we_pk,
  output logic [9:0]  o_enc_addr_pk,
  output logic [7:0]  o_enc_di_pk,
  output logic        o_dec_bwe_sk,
  output logic [9:0]  o_dec_baddr_sk,
  output logic [7:0]  o_dec_bdi_sk,
  output logic [7:0]  o_enc_baddr_h,
  input  logic [7:0]  i_enc_bdout_h,
  output logic [9:0]  o_enc_baddr_c,
  input  logic [7:0]  i_enc_bdout_c,
  output logic        o_dec_bwe_h,
  output logic [7:0]  o_dec_baddr_h,
  output logic [7:0]  o_dec_bdi_h,
  output logic        o_dec_bwe_c,
  output logic [9:0]  o_dec_baddr_c,
  output logic [7:0]  o_dec_bdi_c
);

  localparam logic [10:0] PsBase    = 11'(PS_BASE);
  localparam logic [10:0] PkBase    = 11'(PK_BASE);
  localparam logic [10:0] SkBase    = 11'(SK_BASE);
  localparam logic [9:0]  LastPs    = 10'd31;
  localparam logic [9:0]  LastBlk   = 10'd895;
  localparam logic [9:0]  HLen      = 10'd192;
  localparam logic [1:0]  DrainLast = 2'(RD_LAT);

  localparam logic [1:0] TgtPs = 2'd0;
  localparam logic [1:0] TgtPk = 2'd1;
  localparam logic [1:0] TgtSk = 2'd2;
  localparam logic [1:0] TgtCt = 2'd3;

  typedef enum logic [2:0] {
    StIdle, StKeyPs, StKeyPk, StKeySk, StCt, StDrain
  } state_e;

  state_e      r_state;
  logic [9:0]  r_idx;
  logic [1:0]  r_drain_cnt;
  logic        r_busy;
  logic        r_done;
  logic        r_ovr;
  logic [10:0] r_key_addr;
  logic [7:0]  r_enc_baddr_h;
  logic [9:0]  r_enc_baddr_c;

  // Issue tag travels alongside the read address; r_tag_* delays it by the RAM latency.
  logic                   r_iss_vld;
  logic [1:0]             r_iss_tgt;
  logic [9:0]             r_iss_dst;
  logic [RD_LAT-1:0]      r_tag_vld;
  logic [RD_LAT-1:0][1:0] r_tag_tgt;
  logic [RD_LAT-1:0][9:0] r_tag_dst;
  logic [23:0]            r_ps_acc;

  logic        w_start;
  logic        w_iss_en;
  logic [1:0]  w_iss_tgt;
  logic [9:0]  w_iss_dst;
  logic [10:0] w_key_base;
  logic [10:0] w_key_addr;
  logic        w_wr_vld;
  logic [1:0]  w_wr_tgt;
  logic [9:0]  w_wr_dst;
  logic        w_we_ps;
  logic        w_we_pk;
  logic        w_we_sk;
  logic        w_we_c;
  logic        w_we_h;

  assign w_start = i_start_key | i_start_ct;

  always_comb begin
    w_iss_en  = 1'b1;
    w_iss_tgt = TgtPs;
    w_iss_dst = r_idx;
    unique case (r_state)
      StIdle: begin
        w_iss_en  = w_start;
        w_iss_tgt = i_start_key ? TgtPs : TgtCt;
        w_iss_dst = '0;
      end
      StKeyPs: w_iss_tgt = TgtPs;
      StKeyPk: w_iss_tgt = TgtPk;
      StKeySk: w_iss_tgt = TgtSk;
      StCt:    w_iss_tgt = TgtCt;
      default: w_iss_en  = 1'b0;
    endcase
  end

  always_comb begin
    w_key_base = PsBase;
    case (w_iss_tgt)
      TgtPk:   w_key_base = PkBase;
      TgtSk:   w_key_base = SkBase;
      default: w_key_base = PsBase;
    endcase
  end

  assign w_key_addr = w_key_base + {1'b0, w_iss_dst};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= StIdle;
      r_idx         <= '0;
      r_drain_cnt   <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_ovr         <= 1'b0;
      r_key_addr    <= '0;
      r_enc_baddr_h <= '0;
      r_enc_baddr_c <= '0;
      r_iss_vld     <= 1'b0;
      r_iss_tgt     <= TgtPs;
      r_iss_dst     <= '0;
    end else begin
      r_done    <= 1'b0;
      r_ovr     <= (r_state != StIdle) && w_start;
      r_iss_vld <= w_iss_en;
      r_iss_tgt <= w_iss_tgt;
      r_iss_dst <= w_iss_dst;
      if (w_iss_en) begin
        if (w_iss_tgt == TgtCt) begin
          r_enc_baddr_c <= w_iss_dst;
          r_enc_baddr_h <= (w_iss_dst < HLen) ? w_iss_dst[7:0] : 8'd191;
        end else begin
          r_key_addr <= w_key_addr;
        end
      end
      unique case (r_state)
        StIdle: begin
          if (i_start_key) begin
            r_state <= StKeyPs;
            r_idx   <= 10'd1;
            r_busy  <= 1'b1;
          end else if (i_start_ct) begin
            r_state <= StCt;
            r_idx   <= 10'd1;
            r_busy  <= 1'b1;
          end
        end
        StKeyPs: begin
          if (r_idx == LastPs) begin
            r_state <= StKeyPk;
            r_idx   <= '0;
          end else begin
            r_idx <= r_idx + 10'd1;
          end
        end
        StKeyPk: begin
          if (r_idx == LastBlk) begin
            r_state <= StKeySk;
            r_idx   <= '0;
          end else begin
            r_idx <= r_idx + 10'd1;
          end
        end
        StKeySk, StCt: begin
          if (r_idx == LastBlk) begin
            r_state     <= StDrain;
            r_idx       <= '0;
            r_drain_cnt <= '0;
          end else begin
            r_idx <= r_idx + 10'd1;
          end
        end
        StDrain: begin
          // busy stays up through the done cycle, then both drop together.
          if (r_done) begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
          end else if (r_drain_cnt == DrainLast) begin
            r_done <= 1'b1;
          end else begin
            r_drain_cnt <= r_drain_cnt + 2'd1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign w_wr_vld = r_tag_vld[RD_LAT-1];
  assign w_wr_tgt = r_tag_tgt[RD_LAT-1];
  assign w_wr_dst = r_tag_dst[RD_LAT-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag_vld <= '0;
      r_tag_tgt <= '0;
      r_tag_dst <= '0;
      r_ps_acc  <= '0;
    end else begin
      r_tag_vld[0] <= r_iss_vld;
      r_tag_tgt[0] <= r_iss_tgt;
      r_tag_dst[0] <= r_iss_dst;
      for (int unsigned k = 1; k < RD_LAT; k++) begin
        r_tag_vld[k] <= r_tag_vld[k-1];
        r_tag_tgt[k] <= r_tag_tgt[k-1];
        r_tag_dst[k] <= r_tag_dst[k-1];
      end
      if (w_wr_vld && (w_wr_tgt == TgtPs)) begin
        case (w_wr_dst[1:0])
          2'd0:    r_ps_acc[7:0]   <= i_key_do;
          2'd1:    r_ps_acc[15:8]  <= i_key_do;
          2'd2:    r_ps_acc[23:16] <= i_key_do;
          default: r_ps_acc        <= r_ps_acc;
        endcase
      end
    end
  end

  assign w_we_ps = w_wr_vld && (w_wr_tgt == TgtPs) && (w_wr_dst[1:0] == 2'd3);
  assign w_we_pk = w_wr_vld && (w_wr_tgt == TgtPk);
  assign w_we_sk = w_wr_vld && (w_wr_tgt == TgtSk);
  assign w_we_c  = w_wr_vld && (w_wr_tgt == TgtCt);
  assign w_we_h  = w_we_c && (w_wr_dst < HLen);

  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_ovr         = r_ovr;
  assign o_key_addr    = r_key_addr;
  assign o_enc_baddr_h = r_enc_baddr_h;
  assign o_enc_baddr_c = r_enc_baddr_c;

  // Read data is captured straight off the RAM in the strobe cycle.
  assign o_enc_we_ps    = w_we_ps;
  assign o_enc_addr_ps  = w_we_ps ? w_wr_dst[4:2] : 3'd0;
  assign o_enc_di_ps    = w_we_ps ? {i_key_do, r_ps_acc} : 32'd0;
  assign o_enc_we_pk    = w_we_pk;
  assign o_enc_addr_pk  = w_we_pk ? w_wr_dst : 10'd0;
  assign o_enc_di_pk    = w_we_pk ? i_key_do : 8'd0;
  assign o_dec_bwe_sk   = w_we_sk;
  assign o_dec_baddr_sk = w_we_sk ? w_wr_dst : 10'd0;
  assign o_dec_bdi_sk   = w_we_sk ? i_key_do : 8'd0;
  assign o_dec_bwe_h    = w_we_h;
  assign o_dec_baddr_h  = w_we_h ? w_wr_dst[7:0] : 8'd0;
  assign o_dec_bdi_h    = w_we_h ? i_enc_bdout_h : 8'd0;
  assign o_dec_bwe_c    = w_we_c;
  assign o_dec_baddr_c  = w_we_c ? w_wr_dst : 10'd0;
  assign o_dec_bdi_c    = w_we_c ? i_enc_bdout_c : 8'd0;

endmodule

// File: tb/tb_newhope_xfer_ctrl.sv
// Scoreboard bench: two instances (RD_LAT 1 and 3) driven in lockstep, expected writes queued
// at start and popped as strobes appear.
module tb_newhope_xfer_ctrl;

  typedef logic [46:0] ent_t;  // {kind[4:0] = ps,pk,sk,c,h ; addr[9:0] ; data[31:0]}

  logic clk = 1'b0;
  logic rst_n;
  logic start_key, start_ct;
  int   cyc = 0;
  int   t0 = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        busy0, done0, ovr0, busy1, done1, ovr1;
  logic [10:0] key_addr0, key_addr1;
  logic [7:0]  key_do0, key_do1;
  logic        we_ps0, we_ps1, we_pk0, we_pk1, we_sk0, we_sk1;
  logic [2:0]  a_ps0, a_ps1;
  logic [31:0] d_ps0, d_ps1;
  logic [9:0]  a_pk0, a_pk1, a_sk0, a_sk1;
  logic [7:0]  d_pk0, d_pk1, d_sk0, d_sk1;
  logic [7:0]  ra_h0, ra_h1, rd_h0, rd_h1, rd_c0, rd_c1;
  logic [9:0]  ra_c0, ra_c1;
  logic        we_h0, we_h1, we_c0, we_c1;
  logic [7:0]  a_h0, a_h1, d_h0, d_h1, d_c0, d_c1;
  logic [9:0]  a_c0, a_c1;

  newhope_xfer_ctrl #(.RD_LAT(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .i_start_key(start_key), .i_start_ct(start_ct),
    .o_busy(busy0), .o_done(done0), .o_ovr(ovr0),
    .o_key_addr(key_addr0), .i_key_do(key_do0),
    .o_enc_we_ps(we_ps0), .o_enc_addr_ps(a_ps0), .o_enc_di_ps(d_ps0),
    .o_enc_we_pk(we_pk0), .o_enc_addr_pk(a_pk0), .o_enc_di_pk(d_pk0),
    .o_dec_bwe_sk(we_sk0), .o_dec_baddr_sk(a_sk0), .o_dec_bdi_sk(d_sk0),
    .o_enc_baddr_h(ra_h0), .i_enc_bdout_h(rd_h0),
    .o_enc_baddr_c(ra_c0), .i_enc_bdout_c(rd_c0),
    .o_dec_bwe_h(we_h0), .o_dec_baddr_h(a_h0), .o_dec_bdi_h(d_h0),
    .o_dec_bwe_c(we_c0), .o_dec_baddr_c(a_c0), .o_dec_bdi_c(d_c0)
  );

  newhope_xfer_ctrl #(.RD_LAT(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .i_start_key(start_key), .i_start_ct(start_ct),
    .o_busy(busy1), .o_done(done1), .o_ovr(ovr1),
    .o_key_addr(key_addr1), .i_key_do(key_do1),
    .o_enc_we_ps(we_ps1), .o_enc_addr_ps(a_ps1), .o_enc_di_ps(d_ps1),
    .o_enc_we_pk(we_pk1), .o_enc_addr_pk(a_pk1), .o_enc_di_pk(d_pk1),
    .o_dec_bwe_sk(we_sk1), .o_dec_baddr_sk(a_sk1), .o_dec_bdi_sk(d_sk1),
    .o_enc_baddr_h(ra_h1), .i_enc_bdout_h(rd_h1),
    .o_enc_baddr_c(ra_c1), .i_enc_bdout_c(rd_c1),
    .o_dec_bwe_h(we_h1), .o_dec_baddr_h(a_h1), .o_dec_bdi_h(d_h1),
    .o_dec_bwe_c(we_c1), .o_dec_baddr_c(a_c1), .o_dec_bdi_c(d_c1)
  );

  // Source RAM models: keygen byte = addr[7:0], h = ~addr, c = addr[7:0].
  logic [7:0] k1p [3];
  logic [7:0] h1p [3];
  logic [7:0] c1p [3];
  always @(posedge clk) begin
    key_do0 <= key_addr0[7:0];
    rd_h0   <= ~ra_h0;
    rd_c0   <= ra_c0[7:0];
    k1p[0]  <= key_addr1[7:0];
    h1p[0]  <= ~ra_h1;
    c1p[0]  <= ra_c1[7:0];
    for (int i = 1; i < 3; i++) begin
      k1p[i] <= k1p[i-1];
      h1p[i] <= h1p[i-1];
      c1p[i] <= c1p[i-1];
    end
  end
  assign key_do1 = k1p[2];
  assign rd_h1   = h1p[2];
  assign rd_c1   = c1p[2];

  function automatic ent_t obs_f(
    input logic we_ps, input logic [2:0] a_ps, input logic [31:0] d_ps,
    input logic we_pk, input logic [9:0] a_pk, input logic [7:0] d_pk,
    input logic we_sk, input logic [9:0] a_sk, input logic [7:0] d_sk,
    input logic we_c, input logic [9:0] a_c, input logic [7:0] d_c,
    input logic we_h, input logic [7:0] a_h, input logic [7:0] d_h);
    ent_t e;
    e = '0;
    e[46:42] = {we_ps, we_pk, we_sk, we_c, we_h};
    if (we_ps) begin
      e[41:32] = {7'd0, a_ps};
      e[31:0]  = d_ps;
    end else if (we_pk) begin
      e[41:32] = a_pk;
      e[31:0]  = {24'd0, d_pk};
    end else if (we_sk) begin
      e[41:32] = a_sk;
      e[31:0]  = {24'd0, d_sk};
    end else if (we_c) begin
      e[41:32] = a_c;
      e[31:0]  = {we_h ? a_h : 8'd0, 8'd0, we_h ? d_h : 8'd0, d_c};
    end
    return e;
  endfunction

  ent_t obs0, obs1;
  assign obs0 = obs_f(we_ps0, a_ps0, d_ps0, we_pk0, a_pk0, d_pk0, we_sk0, a_sk0, d_sk0,
                      we_c0, a_c0, d_c0, we_h0, a_h0, d_h0);
  assign obs1 = obs_f(we_ps1, a_ps1, d_ps1, we_pk1, a_pk1, d_pk1, we_sk1, a_sk1, d_sk1,
                      we_c1, a_c1, d_c1, we_h1, a_h1, d_h1);

  ent_t q0[$];
  ent_t q1[$];
  int done_cnt[2], done_rel[2], ovr_cnt[2], ovr_rel[2], bfirst[2], blast[2];
  int hcnt[2], ccnt[2];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic ent_t mk(input logic [4:0] kind, input int addr, input logic [31:0] data);
    return {kind, 10'(addr), data};
  endfunction

  task automatic push_both(input ent_t e);
    q0.push_back(e);
    q1.push_back(e);
  endtask

  task automatic push_key();
    for (int g = 0; g < 8; g++)
      push_both(mk(5'b10000, g, {8'(4*g+3), 8'(4*g+2), 8'(4*g+1), 8'(4*g)}));
    for (int k = 0; k < 896; k++) push_both(mk(5'b01000, k, {24'd0, 8'(896 + k)}));
    for (int k = 0; k < 896; k++) push_both(mk(5'b00100, k, {24'd0, 8'(k)}));
  endtask

  task automatic push_ct();
    logic [7:0] iv;
    for (int i = 0; i < 896; i++) begin
      iv = 8'(i);
      if (i < 192) push_both(mk(5'b00011, i, {iv, 8'd0, ~iv, iv}));
      else         push_both(mk(5'b00010, i, {24'd0, iv}));
    end
  endtask

  task automatic mon_step(input int d, input ent_t obs, input logic busy, input logic done,
                          input logic ovr);
    int   rel;
    ent_t e;
    rel = cyc - t0;
    if (obs[46:42] != 5'd0) begin
      if (obs[1+42] == 1'b1) ccnt[d]++;
      if (obs[42] == 1'b1) hcnt[d]++;
      if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
        check_eq($sformatf("sb%0d_unexpected", d), 64'(obs), 64'd0);
      end else begin
        if (d == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        check_eq($sformatf("sb%0d_write", d), 64'(obs), 64'(e));
      end
    end
    if (busy) begin
      if (bfirst[d] < 0) bfirst[d] = rel;
      blast[d] = rel;
    end
    if (done) begin
      done_cnt[d]++;
      done_rel[d] = rel;
    end
    if (ovr) begin
      ovr_cnt[d]++;
      ovr_rel[d] = rel;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    mon_step(0, obs0, busy0, done0, ovr0);
    mon_step(1, obs1, busy1, done1, ovr1);
    @(posedge clk);
    #1;
  endtask

  task automatic run(input bit key, input bit ct, input int inj_ct_at, input int rst_at);
    int end_rel;
    int exp_done;
    bit is_key;
    is_key = key;
    for (int d = 0; d < 2; d++) begin
      done_cnt[d] = 0; done_rel[d] = -1; ovr_cnt[d] = 0; ovr_rel[d] = -1;
      bfirst[d] = -1; blast[d] = -1; hcnt[d] = 0; ccnt[d] = 0;
    end
    if (is_key) push_key();
    else        push_ct();
    end_rel = is_key ? 1840 : 910;
    t0 = cyc;
    start_key = key;
    start_ct  = ct;
    tick();
    start_key = 1'b0;
    start_ct  = 1'b0;
    while (cyc - t0 < end_rel) begin
      if (cyc - t0 == inj_ct_at) start_ct = 1'b1;
      if (cyc - t0 == rst_at) begin
        rst_n = 1'b0;
        #1;
        check_eq("rst_strobes",
                 64'({we_ps0, we_pk0, we_sk0, we_h0, we_c0, we_ps1, we_pk1, we_sk1, we_h1, we_c1}),
                 64'd0);
        check_eq("rst_busy", 64'({busy0, busy1}), 64'd0);
        check_eq("rst_done", 64'({done0, done1}), 64'd0);
        q0.delete();
        q1.delete();
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        return;
      end
      tick();
      start_ct = 1'b0;
    end
    for (int d = 0; d < 2; d++) begin
      exp_done = (is_key ? 1825 : 897) + (d == 0 ? 1 : 3);
      check_eq($sformatf("left%0d", d), 64'(d == 0 ? q0.size() : q1.size()), 64'd0);
      check_eq($sformatf("done_cnt%0d", d), 64'(done_cnt[d]), 64'd1);
      check_eq($sformatf("done_rel%0d", d), 64'(done_rel[d]), 64'(exp_done));
      check_eq($sformatf("busy_first%0d", d), 64'(bfirst[d]), 64'd1);
      check_eq($sformatf("busy_last%0d", d), 64'(blast[d]), 64'(exp_done));
      check_eq($sformatf("ovr_cnt%0d", d), 64'(ovr_cnt[d]), 64'(inj_ct_at >= 0 ? 1 : 0));
      if (inj_ct_at >= 0)
        check_eq($sformatf("ovr_rel%0d", d), 64'(ovr_rel[d]), 64'(inj_ct_at + 1));
      check_eq($sformatf("h_cnt%0d", d), 64'(hcnt[d]), 64'(is_key ? 0 : 192));
      check_eq($sformatf("c_cnt%0d", d), 64'(ccnt[d]), 64'(is_key ? 0 : 896));
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    start_key = 1'b0;
    start_ct  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_status", 64'({busy0, done0, ovr0, busy1, done1, ovr1}), 64'd0);
    check_eq("reset_key_addr", 64'({key_addr0, key_addr1}), 64'd0);
    check_eq("reset_strobes",
             64'({we_ps0, we_pk0, we_sk0, we_h0, we_c0, we_ps1, we_pk1, we_sk1, we_h1, we_c1}),
             64'd0);
    rst_n = 1'b1;
    tick();

    run(1'b1, 1'b0, -1, -1);  // KEY
    run(1'b0, 1'b1, -1, -1);  // CT
    run(1'b1, 1'b1, -1, -1);  // simultaneous starts: KEY wins, no ovr
    run(1'b1, 1'b0, 100, -1); // start_ct while busy
    run(1'b1, 1'b0, -1, 500); // reset mid-transfer
    run(1'b1, 1'b0, -1, -1);  // fresh KEY after reset

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
